// File: rtl/fingerprint_uart_loader.sv
// 8N1 UART receiver and frame parser that loads matched-filter fingerprint templates
// into the fingerprint RAM. Frame: SYNC_BYTE, CAPTURE_LENGTH payload bytes, 8-bit sum.
module fingerprint_uart_loader #(
    parameter int          CLKS_PER_BIT   = 868,
    parameter int          CAPTURE_LENGTH = 1000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_BITS   = 32,
    localparam int         ADDR_W         = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [7:0]        ram_write_data,
    output logic              ram_we,
    output logic              load_done,
    output logic              checksum_error,
    output logic              framing_error,
    output logic              busy
);

    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CAPTURE_LENGTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_DATA, P_CHECK} p_state_t;

    rx_state_t         rx_state, rx_next;
    p_state_t          p_state, p_next;

    logic              rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              half_tick, bit_tick, rx_fall;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout;

    // Two-flop synchronizer; idle level is high so reset to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timing and shifting; byte_valid/framing_error fire the cycle after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            rx_byte       <= '0;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
                RX_START: begin
                    clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
                    bit_idx <= '0;
                end
                RX_DATA: begin
                    clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
                    if (bit_tick) begin
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
                    if (bit_tick) begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_reg;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    assign timeout = (p_state != P_WAIT_SYNC) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_WAIT_SYNC;
        else        p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_WAIT_SYNC: if (byte_valid && rx_byte == SYNC_BYTE) p_next = P_DATA;
            P_DATA: begin
                if (framing_error || timeout)      p_next = P_WAIT_SYNC;
                else if (byte_valid && addr == ADDR_LAST) p_next = P_CHECK;
            end
            P_CHECK: if (framing_error || timeout || byte_valid) p_next = P_WAIT_SYNC;
            default: p_next = P_WAIT_SYNC;
        endcase
    end

    // Frame datapath: RAM write strobe, running checksum and inter-byte watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we         <= 1'b0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
            load_done      <= 1'b0;
            checksum_error <= 1'b0;
            addr           <= '0;
            sum            <= '0;
            to_cnt         <= '0;
        end else begin
            ram_we    <= 1'b0;
            load_done <= 1'b0;
            to_cnt    <= (p_state == P_WAIT_SYNC || byte_valid) ? '0 : to_cnt + 1'b1;
            case (p_state)
                P_WAIT_SYNC: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        addr           <= '0;
                        sum            <= '0;
                        checksum_error <= 1'b0;
                    end
                end
                P_DATA: begin
                    if (byte_valid) begin
                        ram_we         <= 1'b1;
                        ram_write_addr <= addr;
                        ram_write_data <= rx_byte;
                        sum            <= sum + rx_byte;
                        addr           <= addr + 1'b1;
                    end
                end
                P_CHECK: begin
                    if (byte_valid) begin
                        if (rx_byte == sum) load_done      <= 1'b1;
                        else                checksum_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (p_state != P_WAIT_SYNC);

endmodule

// File: tb/tb_fingerprint_uart_loader.sv
// Scoreboard bench for fingerprint_uart_loader: directed UART frames push expected
// RAM writes / load_done / framing_error events; a monitor pops and compares them.
module tb_fingerprint_uart_loader;

    localparam int CLKS = 16;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [1:0] ram_write_addr;
    logic [7:0] ram_write_data;
    logic       ram_we;
    logic       load_done;
    logic       checksum_error;
    logic       framing_error;
    logic       busy;

    typedef enum logic [1:0] {EV_WRITE, EV_DONE, EV_FERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [1:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    fingerprint_uart_loader #(
        .CLKS_PER_BIT  (CLKS),
        .CAPTURE_LENGTH(4),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_BITS  (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .ram_we        (ram_we),
        .load_done     (load_done),
        .checksum_error(checksum_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expectWrite(input logic [1:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = EV_WRITE; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expectEvent(input ev_kind_t k);
        ev_t e;
        e.kind = k; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [1:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_event_kind", int'(k), 3);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", int'(k), int'(e.kind));
            if (k == EV_WRITE && e.kind == EV_WRITE) begin
                checkOutput("write_addr", int'(a), int'(e.addr));
                checkOutput("write_data", int'(d), int'(e.data));
            end
        end
    endtask

    // Monitor: sample on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we)        observe(EV_WRITE, ram_write_addr, ram_write_data);
            if (load_done)     observe(EV_DONE, 2'd0, 8'd0);
            if (framing_error) observe(EV_FERR, 2'd0, 8'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        idle(CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CLKS);
        end
        uart_rx = stop_ok;
        idle(CLKS);
        uart_rx = 1'b1;
        if (!stop_ok) idle(32);
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        idle(4);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ram_we", int'(ram_we), 0);
        rst_n = 1'b1;
        idle(4);

        $display("[TB] Scenario 1: async reset mid-byte");
        applyStimulus(8'hA5, 1'b1);
        expectWrite(2'd0, 8'h01);
        applyStimulus(8'h01, 1'b1);
        idle(2);
        checkOutput("s1_busy_before_reset", int'(busy), 1);
        uart_rx = 1'b0;
        idle(20);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("s1_async_busy", int'(busy), 0);
        checkOutput("s1_async_data", int'(ram_write_data), 0);
        checkOutput("s1_async_addr", int'(ram_write_addr), 0);
        checkOutput("s1_async_flags", int'({ram_we, load_done, checksum_error, framing_error}), 0);
        uart_rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(100);
        checkOutput("s1_idle_busy", int'(busy), 0);

        $display("[TB] Scenario 2: good frame");
        applyStimulus(8'hA5, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            expectWrite(2'(i - 1), 8'(i));
            applyStimulus(8'(i), 1'b1);
        end
        expectEvent(EV_DONE);
        applyStimulus(8'h0A, 1'b1);
        idle(4);
        checkOutput("s2_checksum_error", int'(checksum_error), 0);
        checkOutput("s2_busy", int'(busy), 0);

        $display("[TB] Scenario 3: bad checksum, cleared by next sync");
        applyStimulus(8'hA5, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            expectWrite(2'(i - 1), 8'(i));
            applyStimulus(8'(i), 1'b1);
        end
        applyStimulus(8'h0B, 1'b1);
        idle(4);
        checkOutput("s3_checksum_error_set", int'(checksum_error), 1);
        checkOutput("s3_busy_after_bad", int'(busy), 0);
        applyStimulus(8'hA5, 1'b1);
        idle(4);
        checkOutput("s3_checksum_error_clr", int'(checksum_error), 0);
        checkOutput("s3_busy_after_sync", int'(busy), 1);
        idle(600);
        checkOutput("s3_busy_after_timeout", int'(busy), 0);

        $display("[TB] Scenario 4: junk before sync, sync value as payload");
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'hA4, 1'b1);
        idle(4);
        checkOutput("s4_busy_junk", int'(busy), 0);
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expectWrite(2'(i), 8'hA5);
            applyStimulus(8'hA5, 1'b1);
        end
        expectEvent(EV_DONE);
        applyStimulus(8'h94, 1'b1);
        idle(4);
        checkOutput("s4_checksum_error", int'(checksum_error), 0);
        checkOutput("s4_busy", int'(busy), 0);

        $display("[TB] Scenario 5: framing error aborts frame");
        applyStimulus(8'hA5, 1'b1);
        expectWrite(2'd0, 8'h01);
        applyStimulus(8'h01, 1'b1);
        expectEvent(EV_FERR);
        applyStimulus(8'h02, 1'b0);
        checkOutput("s5_busy", int'(busy), 0);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h09, 1'b1);
        idle(4);
        checkOutput("s5_busy_after", int'(busy), 0);

        $display("[TB] Scenario 6: glitch and inter-byte timeout");
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(50);
        checkOutput("s6_glitch_busy", int'(busy), 0);
        applyStimulus(8'hA5, 1'b1);
        expectWrite(2'd0, 8'h01);
        applyStimulus(8'h01, 1'b1);
        idle(400);
        checkOutput("s6_busy_before_timeout", int'(busy), 1);
        idle(200);
        checkOutput("s6_busy_after_timeout", int'(busy), 0);

        idle(10);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
